// File: rtl/riscv_cache_setup_skid.sv
// Cache address setup stage: valid/ready handshake with a small skid FIFO,
// registered request to the compare stage and combinational tag/data index.
package riscv_cache_pkg;
  typedef logic [2:0] biu_size_t;
  typedef logic [2:0] biu_prot_t;

  function automatic int calc_sets(input int size_kib, input int block_size, input int ways);
    return (size_kib * 1024 * 8) / (block_size * ways);
  endfunction

  function automatic int calc_blk_offs_bits(input int block_size);
    return $clog2(block_size / 8);
  endfunction

  function automatic int calc_idx_bits(input int size_kib, input int block_size, input int ways);
    return $clog2(calc_sets(size_kib, block_size, ways));
  endfunction

  function automatic int calc_tag_bits(input int xlen, input int size_kib, input int block_size,
                                       input int ways);
    return xlen - calc_idx_bits(size_kib, block_size, ways) - calc_blk_offs_bits(block_size);
  endfunction
endpackage

module riscv_cache_setup_skid
  import riscv_cache_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SIZE       = 64,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS       = 2,
  parameter int DEPTH      = 2,
  localparam int SETS          = calc_sets(SIZE, BLOCK_SIZE, WAYS),
  localparam int BLK_OFFS_BITS = calc_blk_offs_bits(BLOCK_SIZE),
  localparam int IDX_BITS      = calc_idx_bits(SIZE, BLOCK_SIZE, WAYS),
  localparam int TAG_BITS      = calc_tag_bits(XLEN, SIZE, BLOCK_SIZE, WAYS)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                req_i,
  output logic                ready_o,
  input  logic [XLEN-1:0]     adr_i,
  input  biu_size_t           size_i,
  input  logic                lock_i,
  input  biu_prot_t           prot_i,
  input  logic                we_i,
  input  logic [XLEN-1:0]     d_i,
  input  logic                is_cacheable_i,
  input  logic                is_misaligned_i,
  output logic                req_o,
  input  logic                ready_i,
  output logic [XLEN-1:0]     adr_o,
  output biu_size_t           size_o,
  output logic                lock_o,
  output biu_prot_t           prot_o,
  output logic                we_o,
  output logic [XLEN-1:0]     q_o,
  output logic                is_cacheable_o,
  output logic                is_misaligned_o,
  output logic                req_rd_o,
  output logic [IDX_BITS-1:0] tag_idx_o,
  output logic [IDX_BITS-1:0] dat_idx_o,
  output logic [TAG_BITS-1:0] core_tag_o
);

  localparam int PW    = 2 * XLEN + $bits(biu_size_t) + $bits(biu_prot_t) + 4;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ADR_LSB = PW - XLEN;

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("riscv_cache_setup_skid: DEPTH must be within 1..4");
  end

  logic [PW-1:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [IDX_BITS-1:0] held_idx, idx;
  logic                flush_dly;
  logic [PW-1:0]       in_pld, head_pld, nxt_pld;
  logic                accept, advance, fifo_empty, push, pop, nxt_valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_pld   = {adr_i, size_i, lock_i, prot_i, we_i, d_i, is_cacheable_i, is_misaligned_i};
  assign head_pld = fifo_mem[rd_ptr];
  assign ready_o  = (count < CNT_W'(DEPTH));
  assign req_rd_o = req_i & ~we_i & ~flush_i & ready_o;
  assign tag_idx_o = idx;
  assign dat_idx_o = idx;

  // FIFO head has priority over the input so ordering stays strict; only an
  // empty FIFO lets an accepted request bypass straight into the output register.
  always_comb begin
    accept     = req_i & ready_o & ~flush_i;
    advance    = ~req_o | ready_i;
    fifo_empty = (count == '0);
    pop        = advance & ~fifo_empty & ~flush_i;
    push       = accept & ~(advance & fifo_empty);
    nxt_valid  = ~fifo_empty | accept;
    nxt_pld    = fifo_empty ? in_pld : head_pld;
    idx        = held_idx;
    if (flush_dly || (advance && fifo_empty)) begin
      idx = adr_i[BLK_OFFS_BITS +: IDX_BITS];
    end else if (advance) begin
      idx = head_pld[ADR_LSB + BLK_OFFS_BITS +: IDX_BITS];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_o      <= 1'b0;
      {adr_o, size_o, lock_o, prot_o, we_o, q_o, is_cacheable_o, is_misaligned_o} <= '0;
      core_tag_o <= '0;
    end else if (flush_i) begin
      req_o <= 1'b0;
    end else if (advance) begin
      req_o <= nxt_valid;
      if (nxt_valid) begin
        {adr_o, size_o, lock_o, prot_o, we_o, q_o, is_cacheable_o, is_misaligned_o} <= nxt_pld;
        core_tag_o <= nxt_pld[PW-1 -: TAG_BITS];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= in_pld;
  end

  // The memories register idx, so the held copy keeps them pointed at the
  // stalled output request while the compare stage is back-pressured.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_idx  <= '0;
      flush_dly <= 1'b0;
    end else begin
      flush_dly <= flush_i;
      if (advance) held_idx <= idx;
    end
  end

endmodule

// File: tb/tb_riscv_cache_setup_skid.sv
// Bench for riscv_cache_setup_skid: directed scenarios plus random traffic
// checked against a queue-based model of accepted-but-not-consumed requests.
module tb_riscv_cache_setup_skid;
  import riscv_cache_pkg::*;

  localparam int DEPTH    = 2;
  localparam int BLK_OFFS = 2;
  localparam int IDX_BITS = 13;
  localparam int TAG_BITS = 17;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic flush_i, req_i, ready_o, lock_i, we_i, is_cacheable_i, is_misaligned_i;
  logic req_o, ready_i, lock_o, we_o, is_cacheable_o, is_misaligned_o, req_rd_o;
  logic [31:0] adr_i, d_i, adr_o, q_o;
  biu_size_t size_i, size_o;
  biu_prot_t prot_i, prot_o;
  logic [IDX_BITS-1:0] tag_idx_o, dat_idx_o;
  logic [TAG_BITS-1:0] core_tag_o;

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  size;
    logic        lock;
    logic [2:0]  prot;
    logic        we;
    logic [31:0] d;
    logic        cch;
    logic        mis;
  } req_t;

  req_t pend[$];
  bit   prev_flush = 1'b0;
  int   checks = 0, failures = 0;

  riscv_cache_setup_skid #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .req_i(req_i), .ready_o(ready_o),
    .adr_i(adr_i), .size_i(size_i), .lock_i(lock_i), .prot_i(prot_i), .we_i(we_i), .d_i(d_i),
    .is_cacheable_i(is_cacheable_i), .is_misaligned_i(is_misaligned_i),
    .req_o(req_o), .ready_i(ready_i), .adr_o(adr_o), .size_o(size_o), .lock_o(lock_o),
    .prot_o(prot_o), .we_o(we_o), .q_o(q_o), .is_cacheable_o(is_cacheable_o),
    .is_misaligned_o(is_misaligned_o), .req_rd_o(req_rd_o), .tag_idx_o(tag_idx_o),
    .dat_idx_o(dat_idx_o), .core_tag_o(core_tag_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [IDX_BITS-1:0] idx_of(input logic [31:0] a);
    return a[BLK_OFFS +: IDX_BITS];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output is always the oldest pending request; the stage can hold DEPTH more.
  task automatic modelCheck();
    logic exp_req, exp_rdy;
    logic [IDX_BITS-1:0] exp_idx;
    exp_req = (pend.size() > 0);
    exp_rdy = (pend.size() <= DEPTH);
    checkOutput("req_o", req_o, exp_req);
    checkOutput("ready_o", ready_o, exp_rdy);
    checkOutput("req_rd_o", req_rd_o, req_i & ~we_i & ~flush_i & exp_rdy);
    checkOutput("idx_equal", tag_idx_o, dat_idx_o);
    if (!flush_i) begin
      if (prev_flush) exp_idx = idx_of(adr_i);
      else if (pend.size() == 0 || ready_i)
        exp_idx = (pend.size() > 1) ? idx_of(pend[1].adr) : idx_of(adr_i);
      else exp_idx = idx_of(pend[0].adr);
      checkOutput("idx", tag_idx_o, exp_idx);
    end
    if (exp_req) begin
      checkOutput("adr_o", adr_o, pend[0].adr);
      checkOutput("size_o", size_o, pend[0].size);
      checkOutput("lock_o", lock_o, pend[0].lock);
      checkOutput("prot_o", prot_o, pend[0].prot);
      checkOutput("we_o", we_o, pend[0].we);
      checkOutput("q_o", q_o, pend[0].d);
      checkOutput("cacheable_o", is_cacheable_o, pend[0].cch);
      checkOutput("misaligned_o", is_misaligned_o, pend[0].mis);
      checkOutput("core_tag_o", core_tag_o, pend[0].adr >> (32 - TAG_BITS));
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] adr, input logic we,
                               input logic rdy, input logic flush);
    @(negedge clk_i);
    req_i = req; adr_i = adr; we_i = we; ready_i = rdy; flush_i = flush;
    size_i = 3'($urandom); lock_i = 1'($urandom); prot_i = 3'($urandom);
    d_i = $urandom; is_cacheable_i = 1'($urandom); is_misaligned_i = 1'($urandom);
    #1;
    modelCheck();
  endtask

  task automatic clockEdge();
    bit acc, cons;
    req_t cur;
    acc = req_i & (pend.size() <= DEPTH) & ~flush_i;
    cons = (pend.size() > 0) & ready_i;
    cur = '{adr_i, size_i, lock_i, prot_i, we_i, d_i, is_cacheable_i, is_misaligned_i};
    @(posedge clk_i);
    if (flush_i) pend.delete();
    else begin
      if (cons) void'(pend.pop_front());
      if (acc) pend.push_back(cur);
    end
    prev_flush = flush_i;
  endtask

  task automatic cycle(input logic req, input logic [31:0] adr, input logic we,
                       input logic rdy, input logic flush);
    applyStimulus(req, adr, we, rdy, flush);
    clockEdge();
  endtask

  initial begin
    logic [31:0] bp_adr [4];
    bp_adr = '{32'hA000_0100, 32'hB000_0204, 32'hC000_0308, 32'hD000_040C};
    {flush_i, req_i, we_i, ready_i, lock_i, is_cacheable_i, is_misaligned_i} = '0;
    adr_i = '0; d_i = '0; size_i = '0; prot_i = '0;

    repeat (2) @(negedge clk_i);
    #1;
    checkOutput("rst_req_o", req_o, 0);
    checkOutput("rst_ready_o", ready_o, 1);
    checkOutput("rst_adr_o", adr_o, 0);
    checkOutput("rst_q_o", q_o, 0);
    checkOutput("rst_core_tag", core_tag_o, 0);
    @(negedge clk_i) rst_ni = 1'b1;

    applyStimulus(1, 32'h0000_1040, 0, 1, 0);
    checkOutput("rd_idx", tag_idx_o, 13'h410);
    checkOutput("rd_req_rd", req_rd_o, 1);
    clockEdge();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("rd_req_o", req_o, 1);
    checkOutput("rd_adr_o", adr_o, 32'h0000_1040);
    clockEdge();

    for (int i = 0; i < 3; i++) cycle(1, bp_adr[i], 0, 0, 0);
    applyStimulus(1, bp_adr[3], 0, 0, 0);
    checkOutput("bp_ready_full", ready_o, 0);
    clockEdge();
    applyStimulus(1, bp_adr[3], 0, 1, 0);
    checkOutput("bp_out_a", adr_o, bp_adr[0]);
    checkOutput("bp_idx_b", tag_idx_o, idx_of(bp_adr[1]));
    clockEdge();
    applyStimulus(1, bp_adr[3], 0, 1, 0);
    checkOutput("bp_out_b", adr_o, bp_adr[1]);
    checkOutput("bp_ready_d", ready_o, 1);
    clockEdge();
    for (int i = 2; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("bp_out_cd", adr_o, bp_adr[i]);
      clockEdge();
    end
    cycle(0, 0, 0, 1, 0);

    for (int i = 0; i < 3; i++) cycle(1, 32'h0000_7000 + 32'(i * 4), 0, 0, 0);
    applyStimulus(1, 32'h0000_0055, 0, 0, 1);
    checkOutput("flush_req_rd", req_rd_o, 0);
    clockEdge();
    applyStimulus(1, 32'h1234_5ABC, 0, 1, 0);
    checkOutput("flush_req_o", req_o, 0);
    checkOutput("flush_ready_o", ready_o, 1);
    checkOutput("flush_idx", tag_idx_o, idx_of(32'h1234_5ABC));
    clockEdge();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("flush_next_adr", adr_o, 32'h1234_5ABC);
    clockEdge();

    applyStimulus(1, 32'h0000_3000, 1, 1, 0);
    checkOutput("wr_req_rd", req_rd_o, 0);
    clockEdge();
    cycle(0, 0, 0, 1, 0);

    cycle(1, 32'h0000_8000, 0, 0, 0);
    cycle(1, 32'h0000_8004, 0, 0, 0);
    #2;
    req_i = 0; flush_i = 0; ready_i = 0; rst_ni = 1'b0;
    #1;
    checkOutput("midrst_req_o", req_o, 0);
    checkOutput("midrst_ready_o", ready_o, 1);
    pend.delete();
    prev_flush = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    repeat (3) cycle(0, $urandom, 0, 1, 0);

    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
